// File: rtl/lc3b_types.sv
// Shared LC-3b memory-interface types, port FSM states and jitter LFSR helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lc3b_mem_state_t;

  localparam lc3b_word LFSR_SEED_A = 16'hACE1;
  localparam lc3b_word LFSR_SEED_B = 16'h1D87;

  // Fibonacci feedback for taps 16,14,13,11.
  function automatic logic lfsr_feedback(input lc3b_word s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

endpackage

// File: rtl/lc3b_mem_port_fsm.sv
// One memory port: request latch, IDLE/BUSY/DONE sequencing and latency counter.
// With LC3B_MEM_JITTER_EN defined, an LFSR adds 0-3 cycles to each transaction.
module lc3b_mem_port_fsm
  import lc3b_types::*;
#(
  parameter int       DEPTH   = 1024,
  parameter int       LATENCY = 4
`ifdef LC3B_MEM_JITTER_EN
  ,
  parameter lc3b_word SEED    = LFSR_SEED_A
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read,
  input  logic                     write,
  input  lc3b_word                 address,
  input  lc3b_word                 wdata,
  input  lc3b_mem_wmask            mask,
  output logic                     resp,
  output logic                     rd_load,
  output logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     wr_commit,
  output logic [$clog2(DEPTH)-1:0] wr_idx,
  output lc3b_word                 wr_data,
  output lc3b_mem_wmask            wr_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 4);

  lc3b_mem_state_t state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx, load_val;
  logic [AW-1:0]   idx_q;
  logic            op_write_q;
  logic            req;
  logic            unused_addr;

  assign req         = read | write;
  assign unused_addr = ^{address[15:AW+1], address[0]};

`ifdef LC3B_MEM_JITTER_EN
  lc3b_word lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= {lfsr[14:0], lfsr_feedback(lfsr)};
  end

  assign load_val = CW'(LATENCY - 1) + CW'(lfsr[1:0]);
`else
  assign load_val = CW'(LATENCY - 1);
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rd_load  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nx = load_val;
          if (load_val == '0) begin
            state_nx = DONE;
            rd_load  = ~write;
          end else begin
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt <= CW'(1)) begin
          state_nx = DONE;
          cnt_nx   = '0;
          rd_load  = ~op_write_q;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Request payload is captured only at acceptance; it is datapath, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      idx_q      <= address[AW:1];
      wr_data    <= wdata;
      wr_mask    <= mask;
      op_write_q <= write;
    end
  end

  assign rd_idx    = (state == IDLE) ? address[AW:1] : idx_q;
  assign wr_idx    = idx_q;
  assign resp      = (state == DONE);
  assign wr_commit = (state == DONE) && op_write_q && !reset;

endmodule

// File: rtl/lc3b_dual_port_memory.sv
// Dual-port LC-3b physical memory responder: shared word storage, byte-masked
// writes with port-b lane priority, per-port fixed-latency FSMs. Option: LC3B_MEM_JITTER_EN.
module lc3b_dual_port_memory
  import lc3b_types::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pmem_read_a,
  input  logic          pmem_write_a,
  input  lc3b_word      pmem_address_a,
  input  lc3b_word      pmem_wdata_a,
  input  lc3b_mem_wmask pmem_mask_a,
  output logic          pmem_resp_a,
  output lc3b_word      pmem_rdata_a,
  input  logic          pmem_read_b,
  input  logic          pmem_write_b,
  input  lc3b_word      pmem_address_b,
  input  lc3b_word      pmem_wdata_b,
  input  lc3b_mem_wmask pmem_mask_b,
  output logic          pmem_resp_b,
  output lc3b_word      pmem_rdata_b
);

  localparam int AW = $clog2(DEPTH);

  lc3b_word      mem [DEPTH];
  logic          rd_load_a, rd_load_b, wr_commit_a, wr_commit_b;
  logic [AW-1:0] rd_idx_a, rd_idx_b, wr_idx_a, wr_idx_b;
  lc3b_word      wr_data_a, wr_data_b;
  lc3b_mem_wmask wr_mask_a, wr_mask_b;

  lc3b_mem_port_fsm #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
`ifdef LC3B_MEM_JITTER_EN
    ,
    .SEED    (LFSR_SEED_A)
`endif
  ) u_port_a (
    .clk       (clk),
    .reset     (reset),
    .read      (pmem_read_a),
    .write     (pmem_write_a),
    .address   (pmem_address_a),
    .wdata     (pmem_wdata_a),
    .mask      (pmem_mask_a),
    .resp      (pmem_resp_a),
    .rd_load   (rd_load_a),
    .rd_idx    (rd_idx_a),
    .wr_commit (wr_commit_a),
    .wr_idx    (wr_idx_a),
    .wr_data   (wr_data_a),
    .wr_mask   (wr_mask_a)
  );

  lc3b_mem_port_fsm #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
`ifdef LC3B_MEM_JITTER_EN
    ,
    .SEED    (LFSR_SEED_B)
`endif
  ) u_port_b (
    .clk       (clk),
    .reset     (reset),
    .read      (pmem_read_b),
    .write     (pmem_write_b),
    .address   (pmem_address_b),
    .wdata     (pmem_wdata_b),
    .mask      (pmem_mask_b),
    .resp      (pmem_resp_b),
    .rd_load   (rd_load_b),
    .rd_idx    (rd_idx_b),
    .wr_commit (wr_commit_b),
    .wr_idx    (wr_idx_b),
    .wr_data   (wr_data_b),
    .wr_mask   (wr_mask_b)
  );

  // Port b's lane writes are issued last, so they win on a shared word and lane.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_commit_a && wr_mask_a[i]) mem[wr_idx_a][i*8 +: 8] <= wr_data_a[i*8 +: 8];
      if (wr_commit_b && wr_mask_b[i]) mem[wr_idx_b][i*8 +: 8] <= wr_data_b[i*8 +: 8];
    end
  end

  // Read data is captured entering DONE and held until the next read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pmem_rdata_a <= '0;
      pmem_rdata_b <= '0;
    end else begin
      if (rd_load_a) pmem_rdata_a <= mem[rd_idx_a];
      if (rd_load_b) pmem_rdata_b <= mem[rd_idx_b];
    end
  end

endmodule

// File: tb/tb_lc3b_dual_port_memory.sv
// Self-checking bench for lc3b_dual_port_memory: directed table, multi-cycle corner
// sequences and randomized traffic against a word-array reference model.
module tb_lc3b_dual_port_memory;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;
`ifdef LC3B_MEM_JITTER_EN
  localparam int JIT = 3;
`else
  localparam int JIT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pmem_read_a = 1'b0, pmem_write_a = 1'b0;
  logic [15:0] pmem_address_a = '0, pmem_wdata_a = '0;
  logic [1:0]  pmem_mask_a = '0;
  logic        pmem_resp_a;
  logic [15:0] pmem_rdata_a;
  logic        pmem_read_b = 1'b0, pmem_write_b = 1'b0;
  logic [15:0] pmem_address_b = '0, pmem_wdata_b = '0;
  logic [1:0]  pmem_mask_b = '0;
  logic        pmem_resp_b;
  logic [15:0] pmem_rdata_b;

  lc3b_dual_port_memory #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .pmem_read_a    (pmem_read_a),
    .pmem_write_a   (pmem_write_a),
    .pmem_address_a (pmem_address_a),
    .pmem_wdata_a   (pmem_wdata_a),
    .pmem_mask_a    (pmem_mask_a),
    .pmem_resp_a    (pmem_resp_a),
    .pmem_rdata_a   (pmem_rdata_a),
    .pmem_read_b    (pmem_read_b),
    .pmem_write_b   (pmem_write_b),
    .pmem_address_b (pmem_address_b),
    .pmem_wdata_b   (pmem_wdata_b),
    .pmem_mask_b    (pmem_mask_b),
    .pmem_resp_b    (pmem_resp_b),
    .pmem_rdata_b   (pmem_rdata_b)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model [DEPTH];
  logic [15:0] last_rd [2];

  typedef struct {
    int          port;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [1:0]  mask;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int lat);
    checks++;
    if (lat < LAT || lat > LAT + JIT) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d..%0d", name, lat, LAT, LAT + JIT);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return int'(a[15:1]) % DEPTH;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
    int w;
    w = widx(a);
    if (m[0]) model[w][7:0]  = d[7:0];
    if (m[1]) model[w][15:8] = d[15:8];
  endtask

  function automatic logic port_resp(input int port);
    return (port == 0) ? pmem_resp_a : pmem_resp_b;
  endfunction

  function automatic logic [15:0] port_rdata(input int port);
    return (port == 0) ? pmem_rdata_a : pmem_rdata_b;
  endfunction

  task automatic drive(input int port, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] m);
    if (port == 0) begin
      pmem_read_a = rd; pmem_write_a = wr; pmem_address_a = a; pmem_wdata_a = d; pmem_mask_a = m;
    end else begin
      pmem_read_b = rd; pmem_write_b = wr; pmem_address_b = a; pmem_wdata_b = d; pmem_mask_b = m;
    end
  endtask

  // Holds the request until resp, measures cycles from the accepting edge.
  task automatic do_op(input int port, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] m,
                       output logic [15:0] rdat, output int lat);
    drive(port, rd, wr, a, d, m);
    @(posedge clk);
    lat  = -1;
    rdat = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (port_resp(port)) begin
        lat  = k;
        rdat = port_rdata(port);
        break;
      end
    end
    @(posedge clk);
    #1;
    drive(port, 1'b0, 1'b0, a, d, m);
    if (lat < 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      chk("no_double_resp", {31'd0, port_resp(port)}, 32'd0);
    end
  endtask

  task automatic op_chk(input string name, input int port, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] d, input logic [1:0] m,
                        input logic [15:0] exp);
    logic [15:0] rdat;
    int          lat;
    do_op(port, rd, wr, a, d, m, rdat, lat);
    chk_lat(name, lat);
    if (wr) begin
      chk({name, "_hold"}, {16'd0, rdat}, {16'd0, last_rd[port]});
      model_write(a, d, m);
    end else begin
      chk({name, "_rd"}, {16'd0, rdat}, {16'd0, exp});
      last_rd[port] = rdat;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb, a;
    int          la, lb, saw;

    vecs[0]  = '{1, 0, 1, 16'h0020, 16'hBEEF, 2'b11, 16'h0000};
    vecs[1]  = '{0, 1, 0, 16'h0020, 16'h0000, 2'b00, 16'hBEEF};
    vecs[2]  = '{1, 0, 1, 16'h0021, 16'h1234, 2'b01, 16'h0000};
    vecs[3]  = '{0, 1, 0, 16'h0020, 16'h0000, 2'b00, 16'hBE34};
    vecs[4]  = '{1, 1, 0, 16'h0021, 16'h0000, 2'b00, 16'hBE34};
    vecs[5]  = '{0, 0, 1, 16'h0020, 16'hFFFF, 2'b00, 16'h0000};
    vecs[6]  = '{1, 1, 0, 16'h0020, 16'h0000, 2'b00, 16'hBE34};
    vecs[7]  = '{0, 1, 0, 16'h0820, 16'h0000, 2'b00, 16'hBE34};
    vecs[8]  = '{0, 1, 1, 16'h0022, 16'h7777, 2'b11, 16'h0000};
    vecs[9]  = '{1, 1, 0, 16'h0022, 16'h0000, 2'b00, 16'h7777};
    vecs[10] = '{0, 0, 1, 16'h0024, 16'hABCD, 2'b11, 16'h0000};
    vecs[11] = '{1, 0, 1, 16'h0025, 16'h1200, 2'b10, 16'h0000};
    vecs[12] = '{1, 1, 0, 16'h0024, 16'h0000, 2'b00, 16'h12CD};
    vecs[13] = '{1, 0, 1, 16'hF024, 16'h0000, 2'b01, 16'h0000};
    vecs[14] = '{0, 1, 0, 16'h0024, 16'h0000, 2'b00, 16'h1200};
    last_rd[0] = '0;
    last_rd[1] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_resp_a", {31'd0, pmem_resp_a}, 32'd0);
    chk("reset_resp_b", {31'd0, pmem_resp_b}, 32'd0);
    chk("reset_rdata_a", {16'd0, pmem_rdata_a}, 32'd0);
    chk("reset_rdata_b", {16'd0, pmem_rdata_b}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      op_chk($sformatf("vec%0d", i), vecs[i].port, vecs[i].rd, vecs[i].wr,
             vecs[i].addr, vecs[i].wd, vecs[i].mask, vecs[i].exp);

    // Abort: read drops before completion, a fresh read is accepted later.
    saw = 0;
    drive(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);
    @(posedge clk);
    @(negedge clk); saw += int'(pmem_resp_a);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 16'h0020, 16'h0000, 2'b00);
    @(negedge clk); saw += int'(pmem_resp_a);
    @(posedge clk); #1 drive(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);
    @(negedge clk); saw += int'(pmem_resp_a);
    chk("abort_no_resp", saw, 32'd0);
    do_op(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, ra, la);
    chk_lat("abort_reread", la);
    chk("abort_reread_rd", {16'd0, ra}, {16'd0, model[widx(16'h0020)]});
    last_rd[0] = ra;

`ifndef LC3B_MEM_JITTER_EN
    // Same-word writes on both ports in the same cycle: port b owns the shared lane.
    fork
      do_op(0, 1'b0, 1'b1, 16'h0040, 16'hAAAA, 2'b11, ra, la);
      do_op(1, 1'b0, 1'b1, 16'h0040, 16'h5555, 2'b10, rb, lb);
    join
    chk("dual_wr_lat_a", la, LAT);
    chk("dual_wr_lat_b", lb, LAT);
    model[widx(16'h0040)] = 16'h55AA;
    op_chk("dual_wr_rd", 1, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'h55AA);

    // Read and write of one word started together: the read sees the old value.
    fork
      do_op(1, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, rb, lb);
      do_op(0, 1'b0, 1'b1, 16'h0040, 16'h0F0F, 2'b11, ra, la);
    join
    chk("rw_old_data", {16'd0, rb}, 32'h55AA);
    last_rd[1] = rb;
    model_write(16'h0040, 16'h0F0F, 2'b11);
    op_chk("rw_new_data", 0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'h0F0F);
`endif

    // Reset in the middle of a port-b write drops it completely.
    op_chk("rst_pre", 1, 1'b0, 1'b1, 16'h00A0, 16'h0000, 2'b11, 16'h0000);
    drive(1, 1'b0, 1'b1, 16'h00A0, 16'hFFFF, 2'b11);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1, 1'b0, 1'b0, 16'h00A0, 16'hFFFF, 2'b11);
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      saw += int'(pmem_resp_b);
    end
    chk("rst_no_resp", saw, 32'd0);
    chk("rst_rdata_b", {16'd0, pmem_rdata_b}, 32'd0);
    chk("rst_rdata_a", {16'd0, pmem_rdata_a}, 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    op_chk("rst_word", 0, 1'b1, 1'b0, 16'h00A0, 16'h0000, 2'b00, 16'h0000);

    // Randomized traffic over words 0..31 with aliased upper address bits.
    for (int w = 0; w < 32; w++)
      op_chk("init", 0, 1'b0, 1'b1, 16'(w << 1), 16'($urandom), 2'b11, 16'h0000);
    for (int i = 0; i < 80; i++) begin
      int p, kind;
      p    = int'($urandom % 2);
      kind = int'($urandom % 4);
      a    = 16'((($urandom % 32) << 11) | (($urandom % 32) << 1) | ($urandom % 2));
      op_chk("rand", p, kind != 2, kind >= 2, a, 16'($urandom), 2'($urandom),
             model[widx(a)]);
    end
    for (int i = 0; i < 100; i++) begin
      a = 16'((($urandom % 32) << 11) | (($urandom % 32) << 1));
      op_chk("lat_rd", 0, 1'b1, 1'b0, a, 16'h0000, 2'b00, model[widx(a)]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
